// File: rtl/param_bank_if.sv
// Host register bus for param_bank: shadow writes, shadow readback and error flag.
interface param_bank_if #(
  parameter int AW = 8
);
  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [15:0]   i_wr_data;
  logic          i_rd_en;
  logic [AW-1:0] i_rd_addr;
  logic [15:0]   o_rd_data;
  logic          o_rd_valid;
  logic          o_wr_err;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
    input  o_rd_data, o_rd_valid, o_wr_err
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
    output o_rd_data, o_rd_valid, o_wr_err
  );
endinterface

// File: rtl/param_bank.sv
// Double-buffered parameter bank. The host writes a shadow copy; a commit copies
// shadow to active only on a frame boundary, and the active entries selected by
// the current slot drive registered per-channel outputs.
module param_bank #(
  parameter  int N_CH   = 4,
  parameter  int N_SLOT = 4,
  parameter  int MASK_W = 4,
  localparam int N_E    = N_CH * N_SLOT,
  localparam int EW     = (N_E > 1) ? $clog2(N_E) : 1,
  localparam int SW     = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SW-1:0]          i_slot,
  input  logic                   i_frame_start,
  input  logic                   i_commit_req,
  param_bank_if.slave            bus,
  output logic                   o_commit_pending,
  output logic                   o_commit_done,
  output logic [N_SLOT*16-1:0]   o_ts_time,
  output logic [N_CH*MASK_W-1:0] o_pulse_mask,
  output logic [N_CH*8-1:0]      o_pulse_hit,
  output logic [N_CH*8-1:0]      o_pulse_gnd,
  output logic [N_CH*4-1:0]      o_pulse_count,
  output logic [N_CH*16-1:0]     o_pulse_hush,
  output logic [N_CH*2-1:0]      o_adc_vchn,
  output logic [N_CH*8-1:0]      o_adc_tick,
  output logic [N_CH*8-1:0]      o_adc_ratio,
  output logic [N_CH*8-1:0]      o_dac_level
);

  typedef struct packed {
    logic [MASK_W-1:0] mask;
    logic [7:0]        hit;
    logic [7:0]        gnd;
    logic [3:0]        count;
    logic [15:0]       hush;
    logic [1:0]        vchn;
    logic [7:0]        tick;
    logic [7:0]        ratio;
    logic [7:0]        dac;
  } entry_t;

  entry_t      shadow [N_E];
  entry_t      active [N_E];
  entry_t      out_q  [N_CH];
  logic [15:0] ts_sh  [N_SLOT];
  logic [15:0] ts_act [N_SLOT];

  logic [3:0]    wr_f, rd_f;
  logic [EW-1:0] wr_e, rd_e;
  logic          wr_ok, rd_ok, do_copy, pending;
  logic [15:0]   rd_val;

  // Power-on value of entry e = ch*N_SLOT + slot.
  function automatic entry_t default_entry(input int e);
    entry_t d;
    int     slot;
    logic   last;
    slot    = e % N_SLOT;
    last    = (e == N_E - 1);
    d.mask  = MASK_W'(1) << (slot % MASK_W);
    d.hit   = last ? 8'd20  : 8'd100;
    d.gnd   = last ? 8'd180 : 8'd100;
    d.count = last ? 4'd1   : 4'd4;
    d.hush  = 16'd1000;
    d.vchn  = 2'(slot % 4);
    d.tick  = 8'd128;
    d.ratio = 8'd8;
    d.dac   = 8'd80;
    return d;
  endfunction

  function automatic logic [15:0] default_ts(input int s);
    return (s == N_SLOT - 1) ? 16'd5000 : 16'd9000;
  endfunction

  // Fields 0..8 exist for every entry; slot time (field 9) only for e < N_SLOT.
  function automatic logic addr_ok(input logic [EW-1:0] e, input logic [3:0] f);
    return (f <= 4'd8 && int'(e) < N_E) || (f == 4'd9 && int'(e) < N_SLOT);
  endfunction

  assign wr_f    = bus.i_wr_addr[3:0];
  assign wr_e    = bus.i_wr_addr[EW+3:4];
  assign rd_f    = bus.i_rd_addr[3:0];
  assign rd_e    = bus.i_rd_addr[EW+3:4];
  assign wr_ok   = addr_ok(wr_e, wr_f);
  assign rd_ok   = addr_ok(rd_e, rd_f);
  assign do_copy = (pending | i_commit_req) & i_frame_start;

  // Readback mux over the shadow copy; invalid addresses read as zero.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_val = '0;
    if (rd_ok) begin
      case (rd_f)
        4'd0:    rd_val = 16'(shadow[rd_e].mask);
        4'd1:    rd_val = 16'(shadow[rd_e].hit);
        4'd2:    rd_val = 16'(shadow[rd_e].gnd);
        4'd3:    rd_val = 16'(shadow[rd_e].count);
        4'd4:    rd_val = shadow[rd_e].hush;
        4'd5:    rd_val = 16'(shadow[rd_e].vchn);
        4'd6:    rd_val = 16'(shadow[rd_e].tick);
        4'd7:    rd_val = 16'(shadow[rd_e].ratio);
        4'd8:    rd_val = 16'(shadow[rd_e].dac);
        4'd9:    rd_val = ts_sh[rd_e[SW-1:0]];
        default: rd_val = '0;
      endcase
    end
  end

  // Shadow/active banks: defaults on reset, host writes to shadow, commit copies.
  // NOTE: the banks are flop arrays, not RAM, so that reset can restore every default.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < N_E; e++) begin
        shadow[e] <= default_entry(e);
        active[e] <= default_entry(e);
      end
      for (int s = 0; s < N_SLOT; s++) begin
        ts_sh[s]  <= default_ts(s);
        ts_act[s] <= default_ts(s);
      end
    end else begin
      // NOTE: non-blocking assignments make a same-edge copy take the pre-write shadow.
      if (do_copy) begin
        active <= shadow;
        ts_act <= ts_sh;
      end
      if (bus.i_wr_en && wr_ok) begin
        case (wr_f)
          4'd0:    shadow[wr_e].mask  <= bus.i_wr_data[MASK_W-1:0];
          4'd1:    shadow[wr_e].hit   <= bus.i_wr_data[7:0];
          4'd2:    shadow[wr_e].gnd   <= bus.i_wr_data[7:0];
          4'd3:    shadow[wr_e].count <= bus.i_wr_data[3:0];
          4'd4:    shadow[wr_e].hush  <= bus.i_wr_data;
          4'd5:    shadow[wr_e].vchn  <= bus.i_wr_data[1:0];
          4'd6:    shadow[wr_e].tick  <= bus.i_wr_data[7:0];
          4'd7:    shadow[wr_e].ratio <= bus.i_wr_data[7:0];
          4'd8:    shadow[wr_e].dac   <= bus.i_wr_data[7:0];
          4'd9:    ts_sh[wr_e[SW-1:0]] <= bus.i_wr_data;
          default: ;
        endcase
      end
    end
  end

  // Commit arming, done pulse, registered readback and address-error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending        <= 1'b0;
      o_commit_done  <= 1'b0;
      bus.o_rd_data  <= '0;
      bus.o_rd_valid <= 1'b0;
      bus.o_wr_err   <= 1'b0;
    end else begin
      pending        <= do_copy ? 1'b0 : (pending | i_commit_req);
      o_commit_done  <= do_copy;
      bus.o_rd_valid <= bus.i_rd_en;
      bus.o_wr_err   <= (bus.i_wr_en && !wr_ok) || (bus.i_rd_en && !rd_ok);
      if (bus.i_rd_en) bus.o_rd_data <= rd_val;
    end
  end

  assign o_commit_pending = pending;

  // Per-channel output registers follow the active entry of the current slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) out_q[c] <= default_entry(c * N_SLOT);
    end else if (int'(i_slot) < N_SLOT) begin
      for (int c = 0; c < N_CH; c++) out_q[c] <= active[c * N_SLOT + int'(i_slot)];
    end
  end

  // Flatten the per-channel registers and the active slot times onto the ports.
  always_comb begin
    o_ts_time     = '0;
    o_pulse_mask  = '0;
    o_pulse_hit   = '0;
    o_pulse_gnd   = '0;
    o_pulse_count = '0;
    o_pulse_hush  = '0;
    o_adc_vchn    = '0;
    o_adc_tick    = '0;
    o_adc_ratio   = '0;
    o_dac_level   = '0;
    for (int s = 0; s < N_SLOT; s++) o_ts_time[16*s +: 16] = ts_act[s];
    for (int c = 0; c < N_CH; c++) begin
      o_pulse_mask[c*MASK_W +: MASK_W] = out_q[c].mask;
      o_pulse_hit[c*8 +: 8]            = out_q[c].hit;
      o_pulse_gnd[c*8 +: 8]            = out_q[c].gnd;
      o_pulse_count[c*4 +: 4]          = out_q[c].count;
      o_pulse_hush[c*16 +: 16]         = out_q[c].hush;
      o_adc_vchn[c*2 +: 2]             = out_q[c].vchn;
      o_adc_tick[c*8 +: 8]             = out_q[c].tick;
      o_adc_ratio[c*8 +: 8]            = out_q[c].ratio;
      o_dac_level[c*8 +: 8]            = out_q[c].dac;
    end
  end

endmodule

// File: tb/tb_param_bank.sv
// Self-checking bench for param_bank: directed scenarios then random traffic,
// all checked against an array-based reference model of the parameter bank.
module tb_param_bank;
  localparam int N_CH   = 4;
  localparam int N_SLOT = 4;
  localparam int MASK_W = 4;
  localparam int N_E    = N_CH * N_SLOT;
  localparam int EW     = $clog2(N_E);
  localparam int SW     = $clog2(N_SLOT);
  localparam int AW     = EW + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [SW-1:0] slot = '0;
  logic frame_start = 1'b0;
  logic commit_req = 1'b0;
  logic commit_pending, commit_done;
  logic [N_SLOT*16-1:0]   ts_time;
  logic [N_CH*MASK_W-1:0] pulse_mask;
  logic [N_CH*8-1:0]      pulse_hit, pulse_gnd, adc_tick, adc_ratio, dac_level;
  logic [N_CH*4-1:0]      pulse_count;
  logic [N_CH*16-1:0]     pulse_hush;
  logic [N_CH*2-1:0]      adc_vchn;

  param_bank_if #(.AW(AW)) bus ();

  param_bank #(.N_CH(N_CH), .N_SLOT(N_SLOT), .MASK_W(MASK_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_slot(slot), .i_frame_start(frame_start),
    .i_commit_req(commit_req), .bus(bus),
    .o_commit_pending(commit_pending), .o_commit_done(commit_done),
    .o_ts_time(ts_time), .o_pulse_mask(pulse_mask), .o_pulse_hit(pulse_hit),
    .o_pulse_gnd(pulse_gnd), .o_pulse_count(pulse_count), .o_pulse_hush(pulse_hush),
    .o_adc_vchn(adc_vchn), .o_adc_tick(adc_tick), .o_adc_ratio(adc_ratio),
    .o_dac_level(dac_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: field f of entry e in shadow/active; field 9 is slot time.
  int sh  [10][N_E];
  int act [10][N_E];
  int exp_out [9][N_CH];
  bit pending_m, exp_done, exp_err, exp_rv;
  int exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int field_w(input int f);
    case (f)
      0: return MASK_W;
      3: return 4;
      4: return 16;
      5: return 2;
      9: return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int def_val(input int f, input int e);
    int s;
    bit last;
    s = e % N_SLOT;
    last = (e == N_E - 1);
    case (f)
      0: return 1 << (s % MASK_W);
      1: return last ? 20 : 100;
      2: return last ? 180 : 100;
      3: return last ? 1 : 4;
      4: return 1000;
      5: return s % 4;
      6: return 128;
      7: return 8;
      8: return 80;
      default: return (e == N_SLOT - 1) ? 5000 : 9000;
    endcase
  endfunction

  function automatic bit ok(input int a);
    int e, f;
    e = a >> 4;
    f = a & 15;
    return (f <= 8 && e < N_E) || (f == 9 && e < N_SLOT);
  endfunction

  task automatic model_reset();
    for (int f = 0; f < 10; f++)
      for (int e = 0; e < N_E; e++) begin
        sh[f][e]  = def_val(f, e);
        act[f][e] = def_val(f, e);
      end
    for (int f = 0; f < 9; f++)
      for (int c = 0; c < N_CH; c++) exp_out[f][c] = def_val(f, c * N_SLOT);
    pending_m = 0;
    exp_done  = 0;
    exp_err   = 0;
    exp_rv    = 0;
  endtask

  // Apply one clock edge to the model, using the inputs the DUT just sampled.
  task automatic model_edge();
    int wa, ra;
    bit copy;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wa = int'(bus.i_wr_addr);
    ra = int'(bus.i_rd_addr);
    if (int'(slot) < N_SLOT)
      for (int f = 0; f < 9; f++)
        for (int c = 0; c < N_CH; c++) exp_out[f][c] = act[f][c * N_SLOT + int'(slot)];
    exp_rv = bus.i_rd_en;
    if (bus.i_rd_en) exp_q.push_back(ok(ra) ? sh[ra & 15][ra >> 4] : 0);
    exp_err = (bus.i_wr_en && !ok(wa)) || (bus.i_rd_en && !ok(ra));
    copy = (pending_m || commit_req) && frame_start;
    if (copy) act = sh;
    exp_done  = copy;
    pending_m = copy ? 1'b0 : (pending_m | commit_req);
    if (bus.i_wr_en && ok(wa))
      sh[wa & 15][wa >> 4] = int'(bus.i_wr_data) & ((1 << field_w(wa & 15)) - 1);
  endtask

  task automatic check_outputs();
    logic [N_CH*MASK_W-1:0] e_mask;
    logic [N_CH*8-1:0]      e_hit, e_gnd, e_tick, e_ratio, e_dac;
    logic [N_CH*4-1:0]      e_count;
    logic [N_CH*16-1:0]     e_hush;
    logic [N_CH*2-1:0]      e_vchn;
    logic [N_SLOT*16-1:0]   e_ts;
    for (int c = 0; c < N_CH; c++) begin
      e_mask[c*MASK_W +: MASK_W] = MASK_W'(exp_out[0][c]);
      e_hit[c*8 +: 8]    = 8'(exp_out[1][c]);
      e_gnd[c*8 +: 8]    = 8'(exp_out[2][c]);
      e_count[c*4 +: 4]  = 4'(exp_out[3][c]);
      e_hush[c*16 +: 16] = 16'(exp_out[4][c]);
      e_vchn[c*2 +: 2]   = 2'(exp_out[5][c]);
      e_tick[c*8 +: 8]   = 8'(exp_out[6][c]);
      e_ratio[c*8 +: 8]  = 8'(exp_out[7][c]);
      e_dac[c*8 +: 8]    = 8'(exp_out[8][c]);
    end
    for (int s = 0; s < N_SLOT; s++) e_ts[16*s +: 16] = 16'(act[9][s]);
    check("pulse_mask", pulse_mask, e_mask);
    check("pulse_hit", pulse_hit, e_hit);
    check("pulse_gnd", pulse_gnd, e_gnd);
    check("pulse_count", pulse_count, e_count);
    check("pulse_hush", pulse_hush, e_hush);
    check("adc_vchn", adc_vchn, e_vchn);
    check("adc_tick", adc_tick, e_tick);
    check("adc_ratio", adc_ratio, e_ratio);
    check("dac_level", dac_level, e_dac);
    check("ts_time", ts_time, e_ts);
    check("commit_pending", commit_pending, pending_m);
    check("commit_done", commit_done, exp_done);
    check("wr_err", bus.o_wr_err, exp_err);
    check("rd_valid", bus.o_rd_valid, exp_rv);
  endtask

  // One clock: DUT and model advance on posedge, outputs compared on negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    bus.i_wr_en = 0;
    bus.i_rd_en = 0;
    commit_req  = 0;
    frame_start = 0;
  endtask

  task automatic wr(input int a, input int d);
    bus.i_wr_en   = 1;
    bus.i_wr_addr = AW'(a);
    bus.i_wr_data = 16'(d);
  endtask

  task automatic rd(input int a);
    bus.i_rd_en   = 1;
    bus.i_rd_addr = AW'(a);
  endtask

  // Scoreboard monitor: every readback pops the oldest expected value.
  always @(negedge clk) begin
    if (bus.o_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got data %0h with no read outstanding", bus.o_rd_data);
      end else begin
        check("rd_data_sb", bus.o_rd_data, 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.i_wr_en = 0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_rd_en = 0; bus.i_rd_addr = '0;

    // Reset, then walk the slots.
    rst_n = 0;
    step(); step();
    rst_n = 1;
    for (int s = 0; s < N_SLOT; s++) begin
      slot = SW'(s);
      step(); step();
      check("mask_ch0_slot", pulse_mask[MASK_W-1:0], 128'(1 << s));
      check("hit_ch3_slot", pulse_hit[31:24], (s == 3) ? 128'd20 : 128'd100);
      check("ts_reset", ts_time, 64'h1388_2328_2328_2328);
    end

    // Shadow write and readback; active untouched.
    slot = 1;
    wr(8'h51, 16'h0037); step(); idle();
    rd(8'h51); step(); idle();
    check("rd_hit_e5", bus.o_rd_data, 16'h0037);
    check("hit_ch1_no_commit", pulse_hit[15:8], 8'd100);

    // Commit armed ten cycles ahead of the frame strobe.
    commit_req = 1; step(); idle();
    check("pending_0", commit_pending, 1'b1);
    for (int i = 1; i < 10; i++) begin
      step();
      check("pending_wait", commit_pending, 1'b1);
    end
    frame_start = 1; step(); idle();
    check("done_pulse", commit_done, 1'b1);
    check("hit_ch1_one_after", pulse_hit[15:8], 8'd100);
    step();
    check("hit_ch1_two_after", pulse_hit[15:8], 8'h37);
    check("done_cleared", commit_done, 1'b0);

    // Request coincident with frame strobe plus a same-cycle shadow write.
    slot = 0;
    commit_req = 1; frame_start = 1; wr(8'h04, 16'h1234); step(); idle();
    step(); step();
    check("hush_active_old", pulse_hush[15:0], 16'd1000);
    rd(8'h04); step(); idle();
    check("hush_shadow_new", bus.o_rd_data, 16'h1234);
    commit_req = 1; frame_start = 1; step(); idle();
    step();
    check("hush_second_commit", pulse_hush[15:0], 16'h1234);

    // Invalid addresses.
    wr(8'h79, 16'hBEEF); step(); idle();
    check("err_ts_e7", bus.o_wr_err, 1'b1);
    rd(8'h0C); step(); idle();
    check("err_field12", bus.o_wr_err, 1'b1);
    check("rd_invalid_zero", bus.o_rd_data, 16'h0000);
    rd(8'h39); step(); idle();
    check("ts_slot3_unchanged", bus.o_rd_data, 16'd5000);

    // Reset while a commit is pending.
    wr(8'h31, 16'h0011); step();
    wr(8'hF3, 16'h0007); commit_req = 1; step(); idle();
    step();
    rst_n = 0; frame_start = 1; step();
    rst_n = 1; frame_start = 0; step();
    check("no_done_after_reset", commit_done, 1'b0);
    check("pending_after_reset", commit_pending, 1'b0);
    for (int a = 0; a < (1 << AW); a++) begin
      if (ok(a)) begin
        rd(a); step();
      end
    end
    idle(); step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      slot          = SW'($urandom_range(0, N_SLOT - 1));
      commit_req    = ($urandom_range(0, 7) == 0);
      frame_start   = ($urandom_range(0, 5) == 0);
      bus.i_wr_en   = ($urandom_range(0, 2) == 0);
      bus.i_wr_addr = AW'($urandom_range(0, (1 << AW) - 1));
      bus.i_wr_data = 16'($urandom);
      bus.i_rd_en   = ($urandom_range(0, 2) == 0);
      bus.i_rd_addr = ($urandom_range(0, 1) == 0) ? bus.i_wr_addr
                                                 : AW'($urandom_range(0, (1 << AW) - 1));
      step();
    end
    rst_n = 1; idle();
    step(); step();
    check("rd_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
